// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: move and piece encodings plus the shape ROM
// that maps (piece, rotation) to the four occupied cells of the 4x4 box.
package tetris_pkg;

    typedef enum logic [1:0] {
        LEFT   = 2'd0,
        RIGHT  = 2'd1,
        DOWN   = 2'd2,
        ROTATE = 2'd3
    } move_e;

    typedef enum logic [2:0] {
        I       = 3'd0,
        O       = 3'd1,
        T       = 3'd2,
        S       = 3'd3,
        Z       = 3'd4,
        J       = 3'd5,
        L       = 3'd6,
        INVALID = 3'd7
    } piece_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } cell_t;

    typedef cell_t [3:0] cells_t;

    // Each 16-bit word lists four cells as nibbles {row,col}, cell 0 first.
    function automatic logic [15:0] pick_rot(input logic [63:0] table4,
                                             input logic [1:0]  rot);
        logic [15:0] word;
        case (rot)
            2'd0:    word = table4[63:48];
            2'd1:    word = table4[47:32];
            2'd2:    word = table4[31:16];
            default: word = table4[15:0];
        endcase
        return word;
    endfunction

    function automatic cells_t piece_cells(input piece_e     piece,
                                           input logic [1:0] rot);
        logic [15:0] packed_rc;
        cells_t      cells;
        case (piece)
            I:       packed_rc = pick_rot(64'h4567_26AE_89AB_159D, rot);
            O:       packed_rc = pick_rot(64'h1256_1256_1256_1256, rot);
            T:       packed_rc = pick_rot(64'h1456_1569_4569_1459, rot);
            S:       packed_rc = pick_rot(64'h1245_156A_5689_0459, rot);
            Z:       packed_rc = pick_rot(64'h0156_2569_459A_1458, rot);
            J:       packed_rc = pick_rot(64'h0456_1259_456A_1589, rot);
            L:       packed_rc = pick_rot(64'h2456_159A_4568_0159, rot);
            default: packed_rc = '0;
        endcase
        for (int unsigned k = 0; k < 4; k++) begin
            cells[k] = cell_t'(packed_rc[15 - 4*k -: 4]);
        end
        return cells;
    endfunction

endpackage

// File: rtl/move_checker.sv
// Collision checker for the falling tetromino: forms the candidate placement
// for a move and scans its four cells through a synchronous board read port.
module move_checker
    import tetris_pkg::*;
#(
    parameter int BOARD_W = 16,
    parameter int BOARD_H = 20,
    parameter int CELL_W  = 3
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic [1:0]                 Dir,
    input  logic [2:0]                 PieceType,
    input  logic [1:0]                 Rotation,
    input  logic [$clog2(BOARD_W)-1:0] XPOS,
    input  logic [$clog2(BOARD_H)-1:0] YPOS,
    output logic [$clog2(BOARD_H)-1:0] RdRow,
    output logic [$clog2(BOARD_W)-1:0] RdCol,
    input  logic [CELL_W-1:0]          RdData,
    output logic                       Busy,
    output logic                       Done,
    output logic                       CanMove
);

    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);

    typedef logic signed [XW+1:0] sx_t;
    typedef logic signed [YW+1:0] sy_t;

    localparam sx_t           X_LIM = sx_t'(BOARD_W);
    localparam sy_t           Y_LIM = sy_t'(BOARD_H);
    localparam logic [XW-1:0] X_MAX = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(BOARD_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state, next_state;

    // Latched candidate placement
    piece_e     piece;
    logic [1:0] cand_rot;
    sx_t        cand_x;
    sy_t        cand_y;
    logic [1:0] idx;

    // Issue stage tag travels with the address, compare stage sees the data
    logic fail, fail_d;
    logic addr_valid, addr_oob;
    logic cmp_valid, cmp_oob;

    logic          accept, issue;
    logic          busy_d, done_d, can_d;
    piece_e        src_piece;
    logic [1:0]    src_rot, src_idx;
    sx_t           src_x, tx;
    sy_t           src_y, ty;
    cells_t        src_cells;
    cell_t         src_cell;
    logic          oob;
    logic [XW-1:0] col_d;
    logic [YW-1:0] row_d;

    // The address register must show cell k during SCAN k, so the next
    // address is formed from the raw inputs while accepting, else from the latch.
    always_comb begin
        src_piece = piece;
        src_rot   = cand_rot;
        src_x     = cand_x;
        src_y     = cand_y;
        src_idx   = idx + 2'd1;
        if (state == IDLE) begin
            src_piece = piece_e'(PieceType);
            src_rot   = Rotation;
            src_x     = sx_t'({2'b00, XPOS});
            src_y     = sy_t'({2'b00, YPOS});
            src_idx   = '0;
            case (move_e'(Dir))
                LEFT:   src_x   = src_x - sx_t'(1);
                RIGHT:  src_x   = src_x + sx_t'(1);
                DOWN:   src_y   = src_y + sy_t'(1);
                ROTATE: src_rot = Rotation + 2'd1;
            endcase
        end
        src_cells = piece_cells(src_piece, src_rot);
        src_cell  = src_cells[src_idx];
        tx        = src_x + sx_t'(src_cell.col);
        ty        = src_y + sy_t'(src_cell.row);
        oob       = tx[XW+1] || (tx >= X_LIM) || ty[YW+1] || (ty >= Y_LIM);
        col_d     = tx[XW+1] ? '0 : ((tx >= X_LIM) ? X_MAX : tx[XW-1:0]);
        row_d     = ty[YW+1] ? '0 : ((ty >= Y_LIM) ? Y_MAX : ty[YW-1:0]);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (Start) next_state = SCAN;
            SCAN:    if (idx == 2'd3) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && Start;
        issue  = accept || ((state == SCAN) && (idx != 2'd3));
        busy_d = (next_state == SCAN) || (next_state == DRAIN);
        done_d = (next_state == DONE);
        fail_d = fail;
        if (accept) begin
            fail_d = 1'b0;
        end else begin
            if (addr_valid && addr_oob) fail_d = 1'b1;
            if (cmp_valid && !cmp_oob && (RdData != '0)) fail_d = 1'b1;
        end
        can_d = !fail_d && (piece != INVALID);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            piece      <= I;
            cand_rot   <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            idx        <= '0;
            fail       <= 1'b0;
            addr_valid <= 1'b0;
            addr_oob   <= 1'b0;
            cmp_valid  <= 1'b0;
            cmp_oob    <= 1'b0;
            RdRow      <= '0;
            RdCol      <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            CanMove    <= 1'b0;
        end else begin
            fail <= fail_d;
            if (accept) begin
                piece    <= src_piece;
                cand_rot <= src_rot;
                cand_x   <= src_x;
                cand_y   <= src_y;
                idx      <= '0;
            end else if (state == SCAN) begin
                idx <= idx + 2'd1;
            end
            addr_valid <= issue;
            addr_oob   <= issue && oob;
            if (issue) begin
                RdRow <= row_d;
                RdCol <= col_d;
            end
            cmp_valid <= addr_valid;
            cmp_oob   <= addr_oob;
            Busy      <= busy_d;
            Done      <= done_d;
            if (done_d) CanMove <= can_d;
        end
    end

endmodule

// File: tb/tb_move_checker.sv
// Self-checking bench for move_checker: directed vector table, randomized
// checks against a bitmap-based placement model, and protocol sequences.
module tb_move_checker;

    localparam int BW = 16;
    localparam int BH = 20;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [1:0] Dir;
    logic [2:0] PieceType;
    logic [1:0] Rotation;
    logic [3:0] XPOS;
    logic [4:0] YPOS;
    logic [4:0] RdRow;
    logic [3:0] RdCol;
    logic [2:0] RdData;
    logic       Busy;
    logic       Done;
    logic       CanMove;

    move_checker #(.BOARD_W(BW), .BOARD_H(BH), .CELL_W(3)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Dir(Dir),
        .PieceType(PieceType), .Rotation(Rotation), .XPOS(XPOS), .YPOS(YPOS),
        .RdRow(RdRow), .RdCol(RdCol), .RdData(RdData),
        .Busy(Busy), .Done(Done), .CanMove(CanMove)
    );

    always #5 Clock = ~Clock;

    logic [2:0]  board [BH][BW];
    logic [15:0] shape_tab [8][4];   // row-major 4x4 bitmaps, bit 15 = (0,0)

    always @(posedge Clock) begin
        if (int'(RdRow) < BH && int'(RdCol) < BW) RdData <= board[RdRow][RdCol];
        else RdData <= 3'd0;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int p, rot, x, y, dir;
        int cell_r, cell_c, cell_v;
        int exp_can;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    function automatic int model_can(int p, int rot, int x, int y, int dir);
        int nx = x;
        int ny = y;
        int nr = rot;
        if (p == 7) return 0;
        case (dir)
            0:       nx = x - 1;
            1:       nx = x + 1;
            2:       ny = y + 1;
            default: nr = (rot + 1) % 4;
        endcase
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (shape_tab[p][nr][15 - 4*r - c]) begin
                    if (nx + c < 0 || nx + c >= BW || ny + r >= BH) return 0;
                    if (board[ny + r][nx + c] != 3'd0) return 0;
                end
            end
        end
        return 1;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++)
                board[r][c] = 3'd0;
    endtask

    task automatic drive(input int p, input int rot, input int x, input int y, input int dir);
        PieceType = 3'(p);
        Rotation  = 2'(rot);
        XPOS      = 4'(x);
        YPOS      = 5'(y);
        Dir       = 2'(dir);
    endtask

    task automatic add_vec(input string n, input int p, input int rot, input int x, input int y,
                           input int dir, input int cr, input int cc, input int cv, input int e);
        vec_t v;
        v.name = n; v.p = p; v.rot = rot; v.x = x; v.y = y; v.dir = dir;
        v.cell_r = cr; v.cell_c = cc; v.cell_v = cv; v.exp_can = e;
        vecs.push_back(v);
    endtask

    // One check: Start for one cycle, then scramble inputs to prove they were latched.
    task automatic run_and_check(input string name, input int p, input int rot, input int x,
                                 input int y, input int dir, input int exp_can);
        int cyc;
        int done_cyc;
        int busy_bad;
        int can;
        @(negedge Clock);
        drive(p, rot, x, y, dir);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        drive($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 31), $urandom_range(0, 3));
        cyc = 1;
        done_cyc = -1;
        busy_bad = 0;
        while (cyc <= 20) begin
            if (Done) begin
                done_cyc = cyc;
                if (Busy) busy_bad++;
                break;
            end
            if (!Busy) busy_bad++;
            @(posedge Clock); #1;
            cyc++;
        end
        can = int'(CanMove);
        check({name, "_latency"}, done_cyc, 6);
        check({name, "_canmove"}, can, exp_can);
        check({name, "_busy"}, busy_bad, 0);
        @(posedge Clock); #1;
        check({name, "_done_pulse"}, int'(Done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int exp;
        int p, rot, x, y, dir;
        int done_q[$];
        int dones;

        shape_tab[0] = '{16'h0F00, 16'h2222, 16'h00F0, 16'h4444};
        shape_tab[1] = '{16'h6600, 16'h6600, 16'h6600, 16'h6600};
        shape_tab[2] = '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40};
        shape_tab[3] = '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40};
        shape_tab[4] = '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80};
        shape_tab[5] = '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0};
        shape_tab[6] = '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440};
        shape_tab[7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

        Reset = 1'b0;
        Start = 1'b0;
        drive(0, 0, 0, 0, 0);
        clear_board();
        #1 Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check("reset_busy", int'(Busy), 0);
        check("reset_done", int'(Done), 0);
        check("reset_canmove", int'(CanMove), 0);
        check("reset_rdrow", int'(RdRow), 0);
        check("reset_rdcol", int'(RdCol), 0);
        Reset = 1'b0;

        //       name         p rot  x   y dir  cr  cc  cv exp
        add_vec("left_x0",    0, 0,  0,  0, 0,  -1, -1, 0, 0);
        add_vec("left_x1",    0, 0,  1,  0, 0,  -1, -1, 0, 1);
        add_vec("right_x12",  0, 0, 12,  0, 1,  -1, -1, 0, 0);
        add_vec("right_x11",  0, 0, 11,  0, 1,  -1, -1, 0, 1);
        add_vec("floor_y17",  1, 0,  5, 17, 2,  -1, -1, 0, 1);
        add_vec("floor_y18",  1, 0,  5, 18, 2,  -1, -1, 0, 0);
        add_vec("occupied",   0, 0,  0,  0, 1,   1,  4, 2, 0);
        add_vec("occ_clear",  0, 0,  0,  0, 1,  -1, -1, 0, 1);
        add_vec("rotate_i",   0, 0,  0,  0, 3,  -1, -1, 0, 1);
        add_vec("invalid",    7, 0,  0,  0, 3,  -1, -1, 0, 0);
        add_vec("t_rot_wall", 2, 1, 14,  5, 3,  -1, -1, 0, 0);
        add_vec("j_down_hit", 5, 0,  3,  3, 2,   5,  4, 7, 0);

        foreach (vecs[i]) begin
            clear_board();
            if (vecs[i].cell_r >= 0) board[vecs[i].cell_r][vecs[i].cell_c] = 3'(vecs[i].cell_v);
            run_and_check(vecs[i].name, vecs[i].p, vecs[i].rot, vecs[i].x, vecs[i].y,
                          vecs[i].dir, vecs[i].exp_can);
        end

        // Rotation read order: I rot1 occupies column 2, rows 0..3
        clear_board();
        @(negedge Clock);
        drive(0, 0, 0, 0, 3);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rot_addr_row", int'(RdRow), i);
            check("rot_addr_col", int'(RdCol), 2);
            @(posedge Clock); #1;
        end
        check("rot_addr_busy_drain", int'(Busy), 1);
        @(posedge Clock); #1;
        check("rot_addr_done", int'(Done), 1);
        @(posedge Clock); #1;

        // Randomized boards and moves
        for (int iter = 0; iter < 150; iter++) begin
            if (iter % 10 == 0) begin
                for (int r = 0; r < BH; r++)
                    for (int c = 0; c < BW; c++)
                        board[r][c] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            end
            p   = $urandom_range(0, 7);
            rot = $urandom_range(0, 3);
            x   = $urandom_range(0, 15);
            y   = $urandom_range(0, 21);
            dir = $urandom_range(0, 3);
            exp = model_can(p, rot, x, y, dir);
            run_and_check("random", p, rot, x, y, dir, exp);
        end

        // Start held high: one Done every 7 cycles
        clear_board();
        board[9][7] = 3'd1;
        @(negedge Clock);
        drive(2, 1, 6, 3, 2);
        exp = model_can(2, 1, 6, 3, 2);
        Start = 1'b1;
        @(posedge Clock); #1;
        cyc = 1;
        while (cyc <= 26) begin
            if (cyc == 20) Start = 1'b0;
            if (Done) begin
                done_q.push_back(cyc);
                check("held_canmove", int'(CanMove), exp);
            end
            @(posedge Clock); #1;
            cyc++;
        end
        check("held_done_count", done_q.size(), 3);
        foreach (done_q[k]) check("held_done_cycle", done_q[k], 6 + 7 * k);

        // Reset in the middle of a scan aborts it silently
        clear_board();
        run_and_check("pre_reset", 0, 0, 4, 4, 2, 1);
        @(negedge Clock);
        drive(0, 0, 4, 4, 2);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("busy_before_reset", int'(Busy), 1);
        Reset = 1'b1;
        #1;
        check("abort_busy", int'(Busy), 0);
        check("abort_done", int'(Done), 0);
        check("abort_canmove", int'(CanMove), 0);
        check("abort_rdrow", int'(RdRow), 0);
        check("abort_rdcol", int'(RdCol), 0);
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge Clock); #1;
            if (Done) dones++;
        end
        check("abort_no_done", dones, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
